// File: rtl/fetch_stage_pkg.sv
// Shared pipeline definitions for the fetch stage: bubble encoding, reset PC
// and the fetch FSM state encoding.
package fetch_stage_pkg;

    localparam logic [31:0] NOP_INST_DEF = 32'h0000_0013;  // addi x0,x0,0
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_REQ   = 2'd0,
        ST_BUF   = 2'd1,
        ST_DRAIN = 2'd2
    } fetchState_e;

    function automatic logic [31:0] nextPc(input logic [31:0] addr);
        return addr + 32'd4;
    endfunction

    function automatic logic [31:0] alignWord(input logic [31:0] addr);
        return addr & ~32'd3;
    endfunction

endpackage

// File: rtl/fetch_stage_ifid_reg.sv
// IF/ID pipeline register: bubble has priority over load, otherwise hold.
module ifid_reg
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter logic [31:0] NOP_INST = NOP_INST_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        bubble,
    input  logic [31:0] pcNext,
    input  logic [31:0] instNext,
    output logic [31:0] pc,
    output logic [31:0] inst,
    output logic        valid
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc    <= RESET_PC;
            inst  <= NOP_INST;
            valid <= 1'b0;
        end else if (bubble) begin
            pc    <= pcNext;
            inst  <= NOP_INST;
            valid <= 1'b0;
        end else if (load) begin
            pc    <= pcNext;
            inst  <= instNext;
            valid <= 1'b1;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: request FSM with one-entry skid buffer, PC
// tracking and redirect handling feeding the IF/ID register.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter logic [31:0] NOP_INST = NOP_INST_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallIn,
    input  logic        flushIn,
    input  logic [31:0] branchTargetIn,
    output logic        imemReqOut,
    output logic [31:0] imemAddrOut,
    input  logic        imemAckIn,
    input  logic [31:0] imemRdataIn,
    output logic [31:0] IFIDpcOut,
    output logic [31:0] IFIDinstOut,
    output logic        IFIDvalidOut,
    output logic [4:0]  IFIDrs1Out,
    output logic [4:0]  IFIDrs2Out
);

    fetchState_e state;
    logic [31:0] pc;
    logic [31:0] reqAddr;
    logic        bufValid;
    logic [31:0] bufPc;
    logic [31:0] bufInst;

    logic        ifidLoad;
    logic        ifidBubble;
    logic [31:0] ifidPcNext;
    logic [31:0] ifidInstNext;

    logic [31:0] target;
    assign target = alignWord(branchTargetIn);

    // BUF is the only state without an outstanding request; reset gates it off.
    assign imemReqOut  = !rst && (state != ST_BUF);
    assign imemAddrOut = reqAddr;

    always_comb begin
        ifidLoad     = 1'b0;
        ifidBubble   = 1'b0;
        ifidPcNext   = pc;
        ifidInstNext = imemRdataIn;
        if (flushIn) begin
            ifidBubble = 1'b1;
        end else if (!stallIn) begin
            case (state)
                ST_REQ: begin
                    if (imemAckIn) begin
                        ifidLoad   = 1'b1;
                        ifidPcNext = reqAddr;
                    end else begin
                        ifidBubble = 1'b1;
                    end
                end
                ST_BUF: begin
                    ifidLoad     = bufValid;
                    ifidPcNext   = bufPc;
                    ifidInstNext = bufInst;
                end
                default: ifidBubble = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_REQ;
            pc       <= RESET_PC;
            reqAddr  <= RESET_PC;
            bufValid <= 1'b0;
        end else begin
            case (state)
                ST_REQ: begin
                    if (flushIn) begin
                        pc       <= target;
                        bufValid <= 1'b0;
                        if (imemAckIn) reqAddr <= target;
                        else           state   <= ST_DRAIN;
                    end else if (imemAckIn) begin
                        pc <= nextPc(reqAddr);
                        if (stallIn) begin
                            bufValid <= 1'b1;
                            state    <= ST_BUF;
                        end else begin
                            reqAddr <= nextPc(reqAddr);
                        end
                    end
                end
                ST_BUF: begin
                    if (flushIn) begin
                        pc       <= target;
                        reqAddr  <= target;
                        bufValid <= 1'b0;
                        state    <= ST_REQ;
                    end else if (!stallIn) begin
                        bufValid <= 1'b0;
                        reqAddr  <= pc;
                        state    <= ST_REQ;
                    end
                end
                ST_DRAIN: begin
                    // The killed response is dropped; refetch from the redirected pc.
                    if (flushIn) begin
                        pc <= target;
                    end else if (imemAckIn) begin
                        reqAddr <= pc;
                        state   <= ST_REQ;
                    end
                end
                default: state <= ST_REQ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state == ST_REQ && !flushIn && imemAckIn && stallIn) begin
            bufPc   <= reqAddr;
            bufInst <= imemRdataIn;
        end
    end

    ifid_reg #(
        .RESET_PC (RESET_PC),
        .NOP_INST (NOP_INST)
    ) uIfid (
        .clk      (clk),
        .rst      (rst),
        .load     (ifidLoad),
        .bubble   (ifidBubble),
        .pcNext   (ifidPcNext),
        .instNext (ifidInstNext),
        .pc       (IFIDpcOut),
        .inst     (IFIDinstOut),
        .valid    (IFIDvalidOut)
    );

    assign IFIDrs1Out = IFIDinstOut[19:15];
    assign IFIDrs2Out = IFIDinstOut[24:20];

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a behavioural instruction memory and an
// IF/ID expectation queue.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        stallIn;
    logic        flushIn;
    logic [31:0] branchTargetIn;
    logic        imemReqOut;
    logic [31:0] imemAddrOut;
    logic        imemAckIn;
    logic [31:0] imemRdataIn;
    logic [31:0] IFIDpcOut;
    logic [31:0] IFIDinstOut;
    logic        IFIDvalidOut;
    logic [4:0]  IFIDrs1Out;
    logic [4:0]  IFIDrs2Out;

    logic autoMem;
    logic manAck;
    int   memLat;
    int   waitCnt;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        valid;
    } ifidExp_t;

    ifidExp_t expQ[$];

    fetch_stage dut (
        .clk            (clk),
        .rst            (rst),
        .stallIn        (stallIn),
        .flushIn        (flushIn),
        .branchTargetIn (branchTargetIn),
        .imemReqOut     (imemReqOut),
        .imemAddrOut    (imemAddrOut),
        .imemAckIn      (imemAckIn),
        .imemRdataIn    (imemRdataIn),
        .IFIDpcOut      (IFIDpcOut),
        .IFIDinstOut    (IFIDinstOut),
        .IFIDvalidOut   (IFIDvalidOut),
        .IFIDrs1Out     (IFIDrs1Out),
        .IFIDrs2Out     (IFIDrs2Out)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memData(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    // Memory: acks after memLat waiting cycles, or under manual control.
    assign imemRdataIn = memData(imemAddrOut);
    assign imemAckIn   = autoMem ? (imemReqOut && (waitCnt >= memLat)) : manAck;

    always_ff @(posedge clk) begin
        if (rst || !imemReqOut || imemAckIn) waitCnt <= 0;
        else                                 waitCnt <= waitCnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic pushExp(input logic [31:0] pc, input logic [31:0] inst, input logic valid);
        ifidExp_t e;
        e.pc    = pc;
        e.inst  = inst;
        e.valid = valid;
        expQ.push_back(e);
    endtask

    task automatic popCheck(input string tag);
        ifidExp_t e;
        if (expQ.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s observed=empty-queue expected=entry", tag);
        end else begin
            e = expQ.pop_front();
            chk({tag, ".pc"},    IFIDpcOut,               e.pc);
            chk({tag, ".inst"},  IFIDinstOut,             e.inst);
            chk({tag, ".valid"}, {31'd0, IFIDvalidOut},   {31'd0, e.valid});
            chk({tag, ".rs1"},   {27'd0, IFIDrs1Out},     {27'd0, e.inst[19:15]});
            chk({tag, ".rs2"},   {27'd0, IFIDrs2Out},     {27'd0, e.inst[24:20]});
        end
    endtask

    initial begin
        rst = 1'b1; stallIn = 1'b0; flushIn = 1'b0; branchTargetIn = 32'h0;
        autoMem = 1'b1; memLat = 0; manAck = 1'b0;
        tick();
        tick();
        pushExp(32'h0, NOP, 1'b0);
        popCheck("reset");
        chk("resetReq", {31'd0, imemReqOut}, 32'd0);

        rst = 1'b0;
        #1;
        chk("relReq",  {31'd0, imemReqOut}, 32'd1);
        chk("relAddr", imemAddrOut, 32'h0);

        for (int i = 0; i < 3; i++) begin
            pushExp(32'(i * 4), memData(32'(i * 4)), 1'b1);
            tick();
            popCheck("zeroWait");
        end
        chk("seqAddr", imemAddrOut, 32'h0000_000C);
        pushExp(32'hC, memData(32'hC), 1'b1);
        tick();
        popCheck("seqC");

        stallIn = 1'b1;
        chk("stallAckAddr", imemAddrOut, 32'h10);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bufReq", {31'd0, imemReqOut}, 32'd0);
            pushExp(32'hC, memData(32'hC), 1'b1);
            popCheck("stallHold");
        end
        stallIn = 1'b0;
        pushExp(32'h10, memData(32'h10), 1'b1);
        tick();
        popCheck("bufRelease");
        chk("afterBufAddr", imemAddrOut, 32'h14);
        pushExp(32'h14, memData(32'h14), 1'b1);
        tick();
        popCheck("fetch14");

        flushIn = 1'b1; branchTargetIn = 32'h40;
        pushExp(32'h18, NOP, 1'b0);
        tick();
        popCheck("flushAck");
        chk("flushAckAddr", imemAddrOut, 32'h40);

        autoMem = 1'b0; branchTargetIn = 32'h200;
        pushExp(32'h40, NOP, 1'b0);
        tick();
        popCheck("flushNoAck");
        chk("drainAddr0", imemAddrOut, 32'h40);
        chk("drainReq",   {31'd0, imemReqOut}, 32'd1);
        flushIn = 1'b0;
        pushExp(32'h200, NOP, 1'b0);
        tick();
        popCheck("drainWait");
        chk("drainAddr1", imemAddrOut, 32'h40);
        manAck = 1'b1;
        pushExp(32'h200, NOP, 1'b0);
        tick();
        popCheck("drainAck");
        chk("redirAddr", imemAddrOut, 32'h200);
        manAck = 1'b0; autoMem = 1'b1;
        pushExp(32'h200, memData(32'h200), 1'b1);
        tick();
        popCheck("fetch200");

        flushIn = 1'b1; stallIn = 1'b1; branchTargetIn = 32'h80;
        pushExp(32'h204, NOP, 1'b0);
        tick();
        popCheck("flushStall");
        chk("flushStallAddr", imemAddrOut, 32'h80);
        flushIn = 1'b0; stallIn = 1'b0;
        pushExp(32'h80, memData(32'h80), 1'b1);
        tick();
        popCheck("fetch80");

        memLat = 2;
        for (int k = 0; k < 2; k++) begin
            pushExp(32'h84 + 32'(4 * k), NOP, 1'b0);
            tick();
            popCheck("lat2Bubble0");
            pushExp(32'h84 + 32'(4 * k), NOP, 1'b0);
            tick();
            popCheck("lat2Bubble1");
            pushExp(32'h84 + 32'(4 * k), memData(32'h84 + 32'(4 * k)), 1'b1);
            tick();
            popCheck("lat2Valid");
        end

        memLat = 0;
        flushIn = 1'b1; branchTargetIn = 32'hFFFF_FFF8;
        pushExp(32'h8C, NOP, 1'b0);
        tick();
        popCheck("flushHigh");
        chk("wrapAddr0", imemAddrOut, 32'hFFFF_FFF8);
        flushIn = 1'b0;
        pushExp(32'hFFFF_FFF8, memData(32'hFFFF_FFF8), 1'b1);
        tick();
        popCheck("wrapF8");
        chk("wrapAddr1", imemAddrOut, 32'hFFFF_FFFC);
        pushExp(32'hFFFF_FFFC, memData(32'hFFFF_FFFC), 1'b1);
        tick();
        popCheck("wrapFC");
        chk("wrapAddr2", imemAddrOut, 32'h0);
        pushExp(32'h0, memData(32'h0), 1'b1);
        tick();
        popCheck("wrap00");
        chk("wrapAddr3", imemAddrOut, 32'h4);

        stallIn = 1'b1;
        pushExp(32'h0, memData(32'h0), 1'b1);
        tick();
        popCheck("bufBeforeRst");
        chk("bufBeforeRstReq", {31'd0, imemReqOut}, 32'd0);
        rst = 1'b1;
        #1;
        chk("rstInBufReq", {31'd0, imemReqOut}, 32'd0);
        pushExp(32'h0, NOP, 1'b0);
        popCheck("rstInBuf");
        tick();
        rst = 1'b0; stallIn = 1'b0;
        #1;
        chk("rerelReq",  {31'd0, imemReqOut}, 32'd1);
        chk("rerelAddr", imemAddrOut, 32'h0);
        pushExp(32'h0, memData(32'h0), 1'b1);
        tick();
        popCheck("refetch0");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL set the first fetch address after reset.
REQ-002 Parameter NOP_INST, default 32'h0000_0013, SHALL be the bubble encoding (addi x0,x0,0).
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be the asynchronous, active-high reset.
REQ-005 stallIn  input  1  SHALL be the hazard-unit stall request: hold IF/ID and PC.
REQ-006 flushIn  input  1  SHALL be the taken-branch/jump redirect from EX.
REQ-007 branchTargetIn  input  32  SHALL be the redirect address, sampled when flushIn=1.
REQ-008 imemReqOut  output  1  SHALL be the instruction-memory request.
REQ-009 imemAddrOut  output  32  SHALL be the fetch address, word aligned.
REQ-010 imemAckIn  input  1  SHALL indicate imemRdataIn is valid; it may rise in the same cycle as the request.
REQ-011 imemRdataIn  input  32  SHALL be the fetched instruction.
REQ-012 IFIDpcOut / IFIDinstOut  output  32 / 32  SHALL be the IF/ID register PC and instruction.
REQ-013 IFIDvalidOut  output  1  SHALL mark IF/ID as holding a real instruction.
REQ-014 IFIDrs1Out / IFIDrs2Out  output  5 / 5  SHALL be IFIDinstOut[19:15] / [24:20], combinational, for the stall unit.

Function
REQ-015 FSM states SHALL be REQ (request outstanding), BUF (one-entry skid buffer full) and DRAIN (discarding a killed request).
REQ-016 In REQ and DRAIN, imemReqOut SHALL be 1; in BUF it SHALL be 0.
REQ-017 imemAddrOut SHALL come from a reqAddr register and SHALL stay stable while imemReqOut=1 and imemAckIn=0.
REQ-018 flushIn SHALL have priority over stallIn in every state.
REQ-019 REQ, no flush, ack, !stallIn: IF/ID <= {reqAddr, imemRdataIn, valid=1}; pc and reqAddr <= reqAddr+4; stay in REQ.
REQ-020 REQ, no flush, ack, stallIn: buffer <= {reqAddr, imemRdataIn}; pc <= reqAddr+4; IF/ID holds; go to BUF.
REQ-021 REQ, no flush, no ack, !stallIn: IF/ID <= {pc, NOP_INST, valid=0}.
REQ-022 Any state with stallIn=1 and no flush: IF/ID SHALL hold all fields.
REQ-023 BUF, !stallIn, no flush: IF/ID <= {buffer, valid=1}; reqAddr <= pc; go to REQ.
REQ-024 flushIn=1 in any state: IF/ID <= {pc, NOP_INST, valid=0}; pc <= branchTargetIn; buffer is invalidated.
REQ-025 Flush in REQ with ack in the same cycle: the response is discarded; reqAddr <= branchTargetIn; stay in REQ.
REQ-026 Flush in REQ without ack: go to DRAIN; reqAddr holds the old address.
REQ-027 Flush in BUF: reqAddr <= branchTargetIn; go to REQ.
REQ-028 Flush in DRAIN: only pc is updated; stay in DRAIN.
REQ-029 DRAIN with ack: the response is discarded; reqAddr <= pc; go to REQ.
REQ-030 PC arithmetic SHALL be 32-bit modulo: 32'hFFFF_FFFC+4 wraps to 0.
REQ-031 Throughput with a zero-wait memory SHALL be one instruction per cycle; IF/ID latency from ack SHALL be one clock edge.

Reset
REQ-032 While rst=1: state=REQ, pc=reqAddr=RESET_PC, buffer invalid, IFIDpcOut=RESET_PC, IFIDinstOut=NOP_INST, IFIDvalidOut=0, imemReqOut forced to 0.
REQ-033 imemReqOut SHALL assert in the first cycle after rst falls, with imemAddrOut=RESET_PC.
REQ-034 Reset during BUF or DRAIN SHALL drop the buffered or in-flight instruction; the memory SHALL tolerate the abandoned request.

Structure
REQ-035 NOP_INST, RESET_PC default and the FSM state encodings SHALL reside in the shared pipeline package.
REQ-036 The IF/ID register (hold/load/bubble) SHALL be the sub-module ifid_reg; the FSM, PC and buffer SHALL stay in fetch_stage.

Verification
REQ-037 Reset release, zero-wait memory returning addr^32'hA5A5_0000 -> IFIDpcOut 0,4,8 on consecutive cycles, valid=1.
REQ-038 Ack in the same cycle as stallIn=1 for 3 cycles at addr 0x10 -> state BUF, imemReqOut=0, IF/ID unchanged; after release IFIDpcOut=0x10, then fetch of 0x14.
REQ-039 Flush to 0x200 while a request to 0x40 is unacked (ack after 2 cycles) -> imemAddrOut stays 0x40 until ack, data discarded, next request 0x200, IFIDvalidOut=0 meanwhile.
REQ-040 flushIn and stallIn together with target 0x80 -> IFIDvalidOut=0, IFIDinstOut=32'h0000_0013, next imemAddrOut=0x80.
REQ-041 Memory with 2-cycle ack latency -> exactly two valid=0 bubbles between consecutive valid instructions.
REQ-042 Start at 32'hFFFF_FFF8 (via flush) -> fetch addresses FFFF_FFF8, FFFF_FFFC, 0000_0000.
